// File: rtl/avg_pkg.sv
// Shared constants for the eight-input averaging datapath; the collector and the
// averager both import this so the latency value has a single source.
package avg_pkg;

    localparam int unsigned AVG_NSAMP     = 8;
    localparam int unsigned AVG_LATENCY   = 8;
    localparam int unsigned AVG_DATAWIDTH = 16;

    // Collector state encoding
    localparam logic AVG_FILL = 1'b0;
    localparam logic AVG_HOLD = 1'b1;

endpackage

// File: rtl/avg_frame_collector.sv
// Packs handshaked samples into an eight-slot frame, holds it stable for the
// averager latency, then flags the cycle in which the averager result is valid.
module avg_frame_collector
    import avg_pkg::*;
#(
    parameter int unsigned DATAWIDTH = AVG_DATAWIDTH,
    parameter int unsigned HOLD      = AVG_LATENCY
) (
    input  logic                 Clk,
    input  logic                 Rst,
    input  logic [DATAWIDTH-1:0] in_data,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [DATAWIDTH-1:0] a,
    output logic [DATAWIDTH-1:0] b,
    output logic [DATAWIDTH-1:0] c,
    output logic [DATAWIDTH-1:0] d,
    output logic [DATAWIDTH-1:0] e,
    output logic [DATAWIDTH-1:0] f,
    output logic [DATAWIDTH-1:0] g,
    output logic [DATAWIDTH-1:0] h,
    output logic [DATAWIDTH-1:0] num,
    output logic                 busy,
    output logic                 avg_valid
);

    localparam int unsigned HCW = (HOLD > 1) ? $clog2(HOLD + 1) : 1;

    logic                 state;
    logic [DATAWIDTH-1:0] slots [AVG_NSAMP];
    logic [2:0]           count;
    logic [HCW-1:0]       hold_cnt;
    logic [3:0]           count_inc;
    logic                 take;

    assign in_ready  = (state == AVG_FILL);
    assign take      = in_valid && in_ready;
    assign count_inc = {1'b0, count} + 4'd1;

    always_ff @(posedge Clk) begin
        if (Rst) begin
            state     <= AVG_FILL;
            count     <= 3'd0;
            hold_cnt  <= '0;
            num       <= DATAWIDTH'(1);
            busy      <= 1'b0;
            avg_valid <= 1'b0;
            for (int i = 0; i < AVG_NSAMP; i++) slots[i] <= '0;
        end else begin
            avg_valid <= 1'b0;
            case (state)
                AVG_FILL: begin
                    if (take) begin
                        slots[count] <= in_data;
                        count        <= count + 3'd1;
                    end
                    // A transfer together with flush stores first, so num counts it
                    if (take && (count == 3'd7 || flush)) begin
                        state    <= AVG_HOLD;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        num      <= DATAWIDTH'(count_inc);
                    end else if (flush && count != 3'd0) begin
                        state    <= AVG_HOLD;
                        busy     <= 1'b1;
                        hold_cnt <= '0;
                        num      <= DATAWIDTH'(count);
                    end
                end
                default: begin
                    if (hold_cnt == HCW'(HOLD - 1)) begin
                        state     <= AVG_FILL;
                        busy      <= 1'b0;
                        avg_valid <= 1'b1;
                        count     <= 3'd0;
                        for (int i = 0; i < AVG_NSAMP; i++) slots[i] <= '0;
                    end else begin
                        hold_cnt <= hold_cnt + HCW'(1);
                    end
                end
            endcase
        end
    end

    assign a = slots[0];
    assign b = slots[1];
    assign c = slots[2];
    assign d = slots[3];
    assign e = slots[4];
    assign f = slots[5];
    assign g = slots[6];
    assign h = slots[7];

endmodule

// File: tb/tb_avg_frame_collector.sv
// Directed bench for avg_frame_collector: frame packing, flush, backpressure,
// hold timing and reset behaviour, with hand-computed expectations.
module tb_avg_frame_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        flush;
    logic [15:0] a, b, c, d, e, f, g, h, num;
    logic        busy;
    logic        avg_valid;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    avg_frame_collector dut (
        .Clk      (clk),
        .Rst      (rst),
        .in_data  (in_data),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .flush    (flush),
        .a        (a),
        .b        (b),
        .c        (c),
        .d        (d),
        .e        (e),
        .f        (f),
        .g        (g),
        .h        (h),
        .num      (num),
        .busy     (busy),
        .avg_valid(avg_valid)
    );

    // Advance one edge; inputs and sampling both sit 1ns after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [15:0] v, input logic fl);
        in_valid = 1'b1;
        in_data  = v;
        flush    = fl;
        tick();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    function automatic int frame_avg();
        int s;
        s = int'(a) + int'(b) + int'(c) + int'(d) + int'(e) + int'(f) + int'(g) + int'(h);
        return (num == 16'd0) ? -1 : s / int'(num);
    endfunction

    // Ticks until avg_valid, bounded; returns ticks taken and busy cycles seen.
    task automatic wait_avg(output int cyc, output int busy_cyc);
        cyc      = 0;
        busy_cyc = 0;
        while (!avg_valid && cyc < 40) begin
            if (busy) busy_cyc++;
            tick();
            cyc++;
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        checks++;
        if (num !== 16'd1 || in_ready !== 1'b1 || busy !== 1'b0 || avg_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: num=%0d ready=%b busy=%b avg_valid=%b, want 1 1 0 0",
                     num, in_ready, busy, avg_valid);
        end
        checks++;
        if ({a, b, c, d, e, f, g, h} !== 128'd0) begin
            errors++;
            $display("FAIL reset_slots: slots=%h, want 0", {a, b, c, d, e, f, g, h});
        end
    endtask

    task automatic test_empty_flush();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (busy !== 1'b0 || num !== 16'd1 || in_ready !== 1'b1) begin
            errors++;
            $display("FAIL empty_flush: busy=%b num=%0d ready=%b, want 0 1 1", busy, num, in_ready);
        end
    endtask

    task automatic test_full_frame();
        int cyc, bcyc;
        for (int i = 1; i <= 8; i++) send(16'(i), 1'b0);
        checks++;
        if (num !== 16'd8 || busy !== 1'b1 || in_ready !== 1'b0) begin
            errors++;
            $display("FAIL full_e0: num=%0d busy=%b ready=%b, want 8 1 0", num, busy, in_ready);
        end
        checks++;
        if (frame_avg() != 4) begin
            errors++;
            $display("FAIL full_avg: avg=%0d, want 4", frame_avg());
        end
        wait_avg(cyc, bcyc);
        checks++;
        if (cyc != 8 || bcyc != 8) begin
            errors++;
            $display("FAIL full_timing: avg_valid after %0d, busy %0d cycles, want 8 8", cyc, bcyc);
        end
        checks++;
        if (in_ready !== 1'b1 || num !== 16'd8 || a !== 16'd0) begin
            errors++;
            $display("FAIL full_release: ready=%b num=%0d a=%0d, want 1 8 0", in_ready, num, a);
        end
        tick();
        checks++;
        if (avg_valid !== 1'b0) begin
            errors++;
            $display("FAIL full_pulse: avg_valid=%b one cycle later, want 0", avg_valid);
        end
    endtask

    task automatic test_partial_flush();
        int cyc, bcyc;
        send(16'd10, 1'b0);
        send(16'd20, 1'b0);
        send(16'd30, 1'b0);
        flush = 1'b1;
        tick();
        flush = 1'b0;
        checks++;
        if (num !== 16'd3 || {d, e, f, g, h} !== 80'd0 || a !== 16'd10 || c !== 16'd30) begin
            errors++;
            $display("FAIL partial_frame: num=%0d a=%0d c=%0d d..h=%h, want 3 10 30 0",
                     num, a, c, {d, e, f, g, h});
        end
        checks++;
        if (frame_avg() != 20) begin
            errors++;
            $display("FAIL partial_avg: avg=%0d, want 20", frame_avg());
        end
        wait_avg(cyc, bcyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL partial_timing: avg_valid after %0d, want 8", cyc);
        end
    endtask

    task automatic test_flush_transfer();
        int cyc, bcyc;
        send(16'd100, 1'b0);
        send(16'd50, 1'b1);
        checks++;
        if (num !== 16'd2 || busy !== 1'b1 || b !== 16'd50) begin
            errors++;
            $display("FAIL flush_xfer: num=%0d busy=%b b=%0d, want 2 1 50", num, busy, b);
        end
        checks++;
        if (frame_avg() != 75) begin
            errors++;
            $display("FAIL flush_xfer_avg: avg=%0d, want 75", frame_avg());
        end
        wait_avg(cyc, bcyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL flush_xfer_timing: avg_valid after %0d, want 8", cyc);
        end
    endtask

    task automatic test_flush_at_seven();
        int cyc, bcyc;
        for (int i = 0; i < 7; i++) send(16'd5, 1'b0);
        send(16'd13, 1'b1);
        checks++;
        if (num !== 16'd8 || h !== 16'd13 || frame_avg() != 6) begin
            errors++;
            $display("FAIL flush_seven: num=%0d h=%0d avg=%0d, want 8 13 6", num, h, frame_avg());
        end
        wait_avg(cyc, bcyc);
    endtask

    task automatic test_backpressure();
        int cyc;
        logic bad_ready, bad_slot;
        for (int i = 0; i < 8; i++) send(16'(i + 1) * 16'd3, 1'b0);
        bad_ready = 1'b0;
        bad_slot  = 1'b0;
        cyc       = 0;
        in_valid  = 1'b1;
        while (!avg_valid && cyc < 40) begin
            in_data = 16'hA000 + 16'(cyc);
            if (in_ready !== 1'b0) bad_ready = 1'b1;
            if (a !== 16'd3 || h !== 16'd24 || frame_avg() != 13) bad_slot = 1'b1;
            tick();
            cyc++;
        end
        checks++;
        if (bad_ready || bad_slot || cyc != 8) begin
            errors++;
            $display("FAIL backpressure: ready_leak=%b slot_change=%b cycles=%0d, want 0 0 8",
                     bad_ready, bad_slot, cyc);
        end
        in_data = 16'h1234;
        tick();
        in_valid = 1'b0;
        checks++;
        if (a !== 16'h1234 || b !== 16'd0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL bp_first_sample: a=%h b=%h busy=%b, want 1234 0 0", a, b, busy);
        end
    endtask

    task automatic test_reset_mid_hold();
        int cyc, bcyc;
        logic seen;
        do_reset();
        for (int i = 0; i < 8; i++) send(16'd7, 1'b0);
        tick();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        checks++;
        if (num !== 16'd1 || busy !== 1'b0 || in_ready !== 1'b1 || {a, b, c, d, e, f, g, h} !== 128'd0) begin
            errors++;
            $display("FAIL mid_hold_reset: num=%0d busy=%b ready=%b slots=%h, want 1 0 1 0",
                     num, busy, in_ready, {a, b, c, d, e, f, g, h});
        end
        seen = 1'b0;
        for (int i = 0; i < 12; i++) begin
            if (avg_valid) seen = 1'b1;
            tick();
        end
        checks++;
        if (seen !== 1'b0) begin
            errors++;
            $display("FAIL mid_hold_no_valid: avg_valid seen=%b, want 0", seen);
        end
        for (int i = 0; i < 8; i++) send(16'd16, 1'b0);
        checks++;
        if (num !== 16'd8 || frame_avg() != 16) begin
            errors++;
            $display("FAIL post_reset_frame: num=%0d avg=%0d, want 8 16", num, frame_avg());
        end
        wait_avg(cyc, bcyc);
        checks++;
        if (cyc != 8) begin
            errors++;
            $display("FAIL post_reset_timing: avg_valid after %0d, want 8", cyc);
        end
    endtask

    initial begin
        rst      = 1'b1;
        in_data  = '0;
        in_valid = 1'b0;
        flush    = 1'b0;
        #1;
        test_reset();
        test_empty_flush();
        test_full_frame();
        test_partial_flush();
        test_flush_transfer();
        test_flush_at_seven();
        test_backpressure();
        test_reset_mid_hold();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
